// File: rtl/mps_dsp_cfg_sync.sv
// rtl/mps_dsp_cfg_sync.sv - keeps DSP working parameters in step with the PS-written MPS config words
//
// Scans config words 0..NUM_WORDS-1, compares each (masked) with the DSP readback and pushes
// mismatched words over the DSP parameter link, then waits for the readback to echo the value.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN        clock, asynchronous active-low reset
//   i_start, i_auto_en               scan request pulse, periodic scan enable
//   o_cfg_idx, i_cfg_data, i_rb_data index to external registered muxes and their words
//   o_tx_valid/addr/data, i_tx_ready DSP parameter link push handshake
//   o_busy, o_done, o_err, o_err_idx scan status
//   o_push_cnt                       accepted pushes since reset, saturating

module mps_dsp_cfg_sync #(
    parameter int NUM_WORDS   = 19,
    parameter int TIMEOUT_CYC = 4096,
    parameter int MAX_RETRY   = 3,
    parameter int AUTO_PERIOD = 100000
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic        i_start,
    input  logic        i_auto_en,
    output logic [4:0]  o_cfg_idx,
    input  logic [31:0] i_cfg_data,
    input  logic [31:0] i_rb_data,
    output logic        o_tx_valid,
    output logic [4:0]  o_tx_addr,
    output logic [31:0] o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [4:0]  o_err_idx,
    output logic [15:0] o_push_cnt
);

    localparam logic [4:0]  IDX_LAST  = 5'(NUM_WORDS - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] AUTO_LAST = 32'(AUTO_PERIOD - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SET, ST_WAIT1, ST_CMP, ST_PUSH, ST_ECHO, ST_NEXT
    } state_t;

    state_t      state, state_next;
    logic [4:0]  idx;
    logic [7:0]  retry;
    logic [31:0] echo_timer;
    logic [31:0] auto_cnt;

    logic        start_req;
    logic [31:0] cfg_m;
    logic [31:0] rb_m;
    logic        echo_ok;
    logic        timeout;

    // Only the live field of each word is compared and pushed: the setup word
    // carries 4 bits, words 11 and 12 carry 16 bits.
    function automatic logic [31:0] mask_word(input logic [4:0] w_idx, input logic [31:0] d);
        if (w_idx == 5'd0)
            return {28'd0, d[3:0]};
        else if (w_idx == 5'd11 || w_idx == 5'd12)
            return {16'd0, d[15:0]};
        else
            return d;
    endfunction

    assign start_req  = i_start | (i_auto_en & (auto_cnt == AUTO_LAST));
    assign cfg_m      = mask_word(idx, i_cfg_data);
    assign rb_m       = mask_word(idx, i_rb_data);
    assign echo_ok    = (rb_m == o_tx_data);
    assign timeout    = (echo_timer == TO_LAST);
    assign o_tx_valid = (state == ST_PUSH);
    assign o_busy     = (state != ST_IDLE);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_req) state_next = ST_SET;
            ST_SET:   state_next = ST_WAIT1;
            ST_WAIT1: state_next = ST_CMP;
            ST_CMP:   state_next = (cfg_m == rb_m) ? ST_NEXT : ST_PUSH;
            ST_PUSH:  if (i_tx_ready) state_next = ST_ECHO;
            ST_ECHO: begin
                if (echo_ok)
                    state_next = ST_NEXT;
                else if (timeout)
                    state_next = (retry < RETRY_MAX) ? ST_PUSH : ST_IDLE;
            end
            ST_NEXT:  state_next = (idx == IDX_LAST) ? ST_IDLE : ST_SET;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            idx        <= 5'd0;
            retry      <= 8'd0;
            echo_timer <= 32'd0;
            auto_cnt   <= 32'd0;
            o_cfg_idx  <= 5'd0;
            o_tx_addr  <= 5'd0;
            o_tx_data  <= 32'd0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_err_idx  <= 5'd0;
            o_push_cnt <= 16'd0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Auto timer runs only while idle; any scan start reloads it.
                    if (start_req) begin
                        auto_cnt <= 32'd0;
                        idx      <= 5'd0;
                        retry    <= 8'd0;
                        o_err    <= 1'b0;
                    end else if (i_auto_en) begin
                        auto_cnt <= auto_cnt + 32'd1;
                    end else begin
                        auto_cnt <= 32'd0;
                    end
                end
                // The external muxes are registered: the index goes out here and the
                // matching words are sampled two edges later, at the end of CMP.
                ST_SET: o_cfg_idx <= idx;
                ST_CMP: begin
                    if (cfg_m != rb_m) begin
                        o_tx_data <= cfg_m;
                        o_tx_addr <= idx;
                    end
                end
                ST_PUSH: begin
                    if (i_tx_ready) begin
                        echo_timer <= 32'd0;
                        if (o_push_cnt != 16'hFFFF)
                            o_push_cnt <= o_push_cnt + 16'd1;
                    end
                end
                ST_ECHO: begin
                    if (!echo_ok) begin
                        if (timeout) begin
                            if (retry < RETRY_MAX) begin
                                retry <= retry + 8'd1;
                            end else begin
                                o_err     <= 1'b1;
                                o_err_idx <= idx;
                            end
                        end else begin
                            echo_timer <= echo_timer + 32'd1;
                        end
                    end
                end
                ST_NEXT: begin
                    retry <= 8'd0;
                    if (idx == IDX_LAST)
                        o_done <= 1'b1;
                    else
                        idx <= idx + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
